// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame defaults, baud divider derivation and receiver state encoding.
package uart_rx_pkg;

    localparam int unsigned NB_DATA_DEF  = 8;
    localparam int unsigned N_TICKS_DEF  = 16;
    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned BAUD         = 9600;
    // Rounded to nearest: 50 MHz / (9600 * 16) -> 326.
    localparam int unsigned BAUD_DIV_DEF = (CLK_HZ + (BAUD * N_TICKS_DEF) / 2) / (BAUD * N_TICKS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte outputs of the UART receiver.
interface uart_rx_if #(
    parameter int unsigned NB_DATA = 8
);
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_busy;

    modport master (
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversampling tick generator, shared between the UART receiver and transmitter.
module baud_rate_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic tick
);
    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF line synchronizer, oversampled start/data/stop FSM,
// single-cycle done strobe for good frames and error strobe for a low stop bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned NB_DATA  = NB_DATA_DEF,
    parameter int unsigned N_TICKS  = N_TICKS_DEF,
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic     CLOCK,
    input  logic     RESET,
    uart_rx_if.master bus
);
    localparam int unsigned SW = $clog2(N_TICKS);
    localparam int unsigned NW = $clog2(NB_DATA);
    localparam logic [SW-1:0] S_MID  = SW'(N_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    logic tick;

    baud_rate_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .tick (tick)
    );

    logic               rx_meta_q;
    logic               rx_q;
    rx_state_e          state_q;
    logic [SW-1:0]      s_q;
    logic [NW-1:0]      n_q;
    logic [NB_DATA-1:0] shreg_q;
    logic [NB_DATA-1:0] data_q;
    logic               done_q;
    logic               err_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= bus.i_rx;
            rx_q      <= rx_meta_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_q) begin
                        s_q     <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_q == S_MID) begin
                            s_q <= '0;
                            n_q <= '0;
                            // A high line at mid-start is a glitch: drop back silently.
                            state_q <= rx_q ? IDLE : DATA;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            shreg_q <= {rx_q, shreg_q[NB_DATA-1:1]};
                            if (n_q == N_LAST) begin
                                n_q     <= '0;
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            state_q <= IDLE;
                            if (rx_q) begin
                                data_q <= shreg_q;
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_frame_err = err_q;
    assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes popped on each done strobe.
module tb_uart_rx;

    localparam int unsigned NB  = 8;
    localparam int unsigned NT  = 16;
    localparam int unsigned BD  = 4;
    localparam int unsigned BIT = NT * BD;
    localparam int LAT_MIN = 596;
    localparam int LAT_MAX = 624;

    typedef struct {
        logic [NB-1:0] data;
        int            start;
    } exp_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   cyc   = 0;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;

    uart_rx_if #(.NB_DATA(NB)) bus ();

    uart_rx #(
        .NB_DATA (NB),
        .N_TICKS (NT),
        .BAUD_DIV(BD)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_bits(input int unsigned nbits);
        repeat (nbits * BIT) @(negedge CLOCK);
    endtask

    // Caller is always at a negedge, so frames chain without any idle gap.
    task automatic send_byte(input logic [NB-1:0] b);
        exp_t e;
        e.data  = b;
        e.start = cyc;
        sb.push_back(e);
        bus.i_rx = 1'b0;
        wait_bits(1);
        for (int unsigned i = 0; i < NB; i++) begin
            bus.i_rx = b[i];
            wait_bits(1);
        end
        bus.i_rx = 1'b1;
        wait_bits(1);
    endtask

    // Monitor: pops the scoreboard on every done strobe.
    initial begin
        logic prev_done;
        exp_t e;
        int   lat;
        prev_done = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (!RESET) begin
                if (prev_done) check("done_width", 32'(bus.o_rx_done), 32'd0);
                if (bus.o_rx_done || bus.o_frame_err)
                    check("done_err_excl", 32'(bus.o_rx_done & bus.o_frame_err), 32'd0);
                if (bus.o_frame_err) err_cnt++;
                if (bus.o_rx_done) begin
                    done_cnt++;
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e   = sb.pop_front();
                        lat = cyc - e.start;
                        check("rx_data", 32'(bus.o_data), 32'(e.data));
                        check("rx_latency", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
                    end
                end
            end
            prev_done = bus.o_rx_done;
        end
    end

    initial begin
        bus.i_rx = 1'b1;
        RESET    = 1'b1;
        repeat (3) @(negedge CLOCK);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_done", 32'(bus.o_rx_done), 32'd0);
        check("rst_err", 32'(bus.o_frame_err), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        RESET = 1'b0;

        repeat (2000) @(negedge CLOCK);
        check("idle_done", 32'(done_cnt), 32'd0);
        check("idle_err", 32'(err_cnt), 32'd0);
        check("idle_busy", 32'(bus.o_busy), 32'd0);

        send_byte(8'h03);
        wait_bits(2);
        check("single_cnt", 32'(done_cnt), 32'd1);
        check("single_data", 32'(bus.o_data), 32'h03);

        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h24);
        wait_bits(2);
        check("b2b_cnt", 32'(done_cnt), 32'd4);
        check("b2b_data", 32'(bus.o_data), 32'h24);

        // False start: low for 3 ticks only.
        bus.i_rx = 1'b0;
        repeat (3 * BD) @(negedge CLOCK);
        bus.i_rx = 1'b1;
        repeat (NT * BD / 2 + 8) @(negedge CLOCK);
        check("fstart_busy", 32'(bus.o_busy), 32'd0);
        wait_bits(12);
        check("fstart_done", 32'(done_cnt), 32'd4);
        check("fstart_err", 32'(err_cnt), 32'd0);
        check("fstart_data", 32'(bus.o_data), 32'h24);

        // Framing error: 0x20 with a low stop bit, released shortly after mid-bit.
        bus.i_rx = 1'b0;
        wait_bits(1);
        for (int unsigned i = 0; i < NB; i++) begin
            bus.i_rx = (i == 5) ? 1'b1 : 1'b0;
            wait_bits(1);
        end
        bus.i_rx = 1'b0;
        repeat (BIT / 2 + 12) @(negedge CLOCK);
        bus.i_rx = 1'b1;
        wait_bits(14);
        check("ferr_err", 32'(err_cnt), 32'd1);
        check("ferr_done", 32'(done_cnt), 32'd4);
        check("ferr_data", 32'(bus.o_data), 32'h24);
        check("ferr_busy", 32'(bus.o_busy), 32'd0);

        // Reset during data bit 4 of 0xA5.
        bus.i_rx = 1'b0;
        wait_bits(1);
        for (int unsigned i = 0; i < 4; i++) begin
            bus.i_rx = (8'hA5 >> i) & 8'h01;
            wait_bits(1);
        end
        bus.i_rx = 1'b0;
        repeat (BIT / 2) @(negedge CLOCK);
        check("mid_busy", 32'(bus.o_busy), 32'd1);
        RESET    = 1'b1;
        bus.i_rx = 1'b1;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        check("mid_rst_data", 32'(bus.o_data), 32'd0);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        wait_bits(12);
        check("mid_no_done", 32'(done_cnt), 32'd4);
        check("mid_no_err", 32'(err_cnt), 32'd1);

        send_byte(8'h5A);
        wait_bits(2);
        check("post_rst_cnt", 32'(done_cnt), 32'd5);
        check("post_rst_data", 32'(bus.o_data), 32'h5A);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
